// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited request issue to instruction memory,
// in-order response tracking with flush discard, and a 2-entry decode FIFO.
module instr_fetch #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   input  logic            imem_err_i,
   output logic            id_valid_o,
   input  logic            id_ready_i,
   output logic [31:0]     id_instr_o,
   output logic [XLEN-1:0] id_pc_o,
   output logic            id_fault_o
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic            fault;
   } fetch_entry_t;

   logic [1:0]      out_q, out_d;
   logic [1:0]      dis_q, dis_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] pcq_q [2];
   logic [XLEN-1:0] pcq_d [2];
   logic            pcq_wr_q, pcq_wr_d;
   logic            pcq_rd_q, pcq_rd_d;
   fetch_entry_t    fifo_q [2];
   fetch_entry_t    fifo_d [2];
   logic            fifo_wr_q, fifo_wr_d;
   logic            fifo_rd_q, fifo_rd_d;

   logic       xfer;
   logic       accept;
   logic       rsp;
   logic       rsp_keep;
   logic       pop;
   logic [2:0] credit;

   assign id_valid_o = (cnt_q != 2'd0);
   assign id_instr_o = fifo_q[fifo_rd_q].instr;
   assign id_pc_o    = fifo_q[fifo_rd_q].pc;
   assign id_fault_o = fifo_q[fifo_rd_q].fault;

   // Slots already owed to the FIFO (outstanding + buffered) minus this cycle's drain.
   assign xfer        = id_valid_o & id_ready_i;
   assign credit      = {1'b0, out_q} + {1'b0, cnt_q} - {2'b00, xfer};
   assign imem_req_o  = ~rst_i & ~flush_i & (credit < 3'd2);
   assign imem_addr_o = pc_i;
   assign accept      = imem_req_o & imem_gnt_i;
   assign stall_o     = rst_i | (~accept & ~flush_i);

   assign rsp      = imem_rvalid_i & (out_q != 2'd0);
   assign rsp_keep = rsp & (dis_q == 2'd0) & ~flush_i;
   assign pop      = xfer & ~flush_i;

   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block infers a latch.
      out_d     = out_q + {1'b0, accept} - {1'b0, rsp};
      dis_d     = dis_q;
      cnt_d     = cnt_q;
      pcq_d     = pcq_q;
      pcq_wr_d  = pcq_wr_q;
      pcq_rd_d  = pcq_rd_q;
      fifo_d    = fifo_q;
      fifo_wr_d = fifo_wr_q;
      fifo_rd_d = fifo_rd_q;

      if (accept) begin
         pcq_d[pcq_wr_q] = pc_i;
         pcq_wr_d        = ~pcq_wr_q;
      end
      if (rsp) pcq_rd_d = ~pcq_rd_q;

      if (flush_i) begin
         // Everything still in flight after this edge belongs to the old stream.
         dis_d     = out_q - {1'b0, rsp};
         cnt_d     = 2'd0;
         fifo_wr_d = 1'b0;
         fifo_rd_d = 1'b0;
      end else begin
         if (rsp && (dis_q != 2'd0)) dis_d = dis_q - 2'd1;
         if (rsp_keep) begin
            fifo_d[fifo_wr_q].instr = imem_err_i ? NOP_INSTR : imem_rdata_i;
            fifo_d[fifo_wr_q].pc    = pcq_q[pcq_rd_q];
            fifo_d[fifo_wr_q].fault = imem_err_i;
            fifo_wr_d               = ~fifo_wr_q;
         end
         if (pop) fifo_rd_d = ~fifo_rd_q;
         cnt_d = cnt_q + {1'b0, rsp_keep} - {1'b0, pop};
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q     <= 2'd0;
         dis_q     <= 2'd0;
         cnt_q     <= 2'd0;
         pcq_wr_q  <= 1'b0;
         pcq_rd_q  <= 1'b0;
         fifo_wr_q <= 1'b0;
         fifo_rd_q <= 1'b0;
         // NOTE: FIFO storage is reset because id_* must read zero out of reset; the PC queue is not.
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
      end else begin
         out_q     <= out_d;
         dis_q     <= dis_d;
         cnt_q     <= cnt_d;
         pcq_wr_q  <= pcq_wr_d;
         pcq_rd_q  <= pcq_rd_d;
         fifo_wr_q <= fifo_wr_d;
         fifo_rd_q <= fifo_rd_d;
         fifo_q    <= fifo_d;
      end
      pcq_q <= pcq_d;
   end

   a_fifo_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(rsp_keep && (cnt_q == 2'd2) && !pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: PC and memory models drive the DUT,
// a scoreboard queue holds the expected decode stream.
module tb_instr_fetch;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] pc_i;
   logic        flush_i;
   logic        stall_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        imem_err_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc_o;
   logic        id_fault_o;

   instr_fetch #(.XLEN(32)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .pc_i         (pc_i),
      .flush_i      (flush_i),
      .stall_o      (stall_o),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_gnt_i   (imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i (imem_rdata_i),
      .imem_err_i   (imem_err_i),
      .id_valid_o   (id_valid_o),
      .id_ready_i   (id_ready_i),
      .id_instr_o   (id_instr_o),
      .id_pc_o      (id_pc_o),
      .id_fault_o   (id_fault_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic rst;
      logic flush;
      logic gnt;
      logic exp_req;
      logic exp_stall;
   } vec_t;

   exp_t  exp_q [$];
   mreq_t mq [$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_xfer   = 0;
   int n_fault  = 0;

   logic [31:0] pc_model     = 32'h0;
   logic [31:0] flush_target = 32'h0;
   logic [31:0] err_addr     = 32'hFFFF_FFFF;
   logic        gnt_en       = 1'b0;
   logic        rsp_en       = 1'b0;

   logic        s_req, s_stall, s_valid, s_fault;
   logic [31:0] s_pc, s_instr, s_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // One clock cycle: drive at the falling edge, sample, then advance the models at the rising edge.
   task automatic step();
      exp_t e;
      pc_i       = pc_model;
      imem_gnt_i = gnt_en;
      if (rsp_en && mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = mem_word(mq[0].addr);
         imem_err_i    = (mq[0].addr == err_addr);
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = $urandom;
         imem_err_i    = 1'b0;
      end
      #1;
      s_req   = imem_req_o;
      s_stall = stall_o;
      s_valid = id_valid_o;
      s_pc    = id_pc_o;
      s_instr = id_instr_o;
      s_fault = id_fault_o;
      s_addr  = imem_addr_o;
      if (s_req) check("imem_addr", s_addr, pc_i);
      if (!rst_i && !flush_i && s_valid && id_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL xfer_unexpected: got pc %h expected no transfer (cycle %0d)", s_pc, cyc);
         end else begin
            e = exp_q.pop_front();
            check("xfer_pc", s_pc, e.pc);
            check("xfer_instr", s_instr, e.instr);
            check("xfer_fault", 32'(s_fault), 32'(e.fault));
            n_xfer++;
            if (s_fault) n_fault++;
         end
      end
      @(posedge clk_i);
      if (rst_i) begin
         pc_model = 32'h0;
         mq.delete();
         exp_q.delete();
      end else begin
         if (s_req && imem_gnt_i) begin
            mq.push_back('{addr: pc_i, due: cyc + 1});
            e.pc    = pc_i;
            e.fault = (pc_i == err_addr);
            e.instr = e.fault ? 32'h0000_0013 : mem_word(pc_i);
            exp_q.push_back(e);
         end
         if (imem_rvalid_i) void'(mq.pop_front());
         if (flush_i) begin
            exp_q.delete();
            pc_model = flush_target;
         end else if (!s_stall) begin
            pc_model = pc_model + 32'd4;
         end
      end
      cyc++;
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_i      = 1'b1;
      flush_i    = 1'b0;
      gnt_en     = 1'b0;
      rsp_en     = 1'b0;
      id_ready_i = 1'b0;
      err_addr   = 32'hFFFF_FFFF;
      step();
      step();
      rst_i = 1'b0;
   endtask

   task automatic drain(input string name);
      gnt_en     = 1'b0;
      rsp_en     = 1'b1;
      id_ready_i = 1'b1;
      flush_i    = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0 && mq.size() == 0) break;
         step();
      end
      check(name, 32'(exp_q.size()), 32'd0);
      step();
      check({name, "_idle"}, 32'(s_valid), 32'd0);
   endtask

   initial begin
      vec_t vecs [6];
      int   cnt_a, cnt_b;

      rst_i         = 1'b1;
      flush_i       = 1'b0;
      pc_i          = 32'h0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
      imem_err_i    = 1'b0;
      id_ready_i    = 1'b0;

      vecs[0] = '{rst: 1'b1, flush: 1'b0, gnt: 1'b1, exp_req: 1'b0, exp_stall: 1'b1};
      vecs[1] = '{rst: 1'b1, flush: 1'b1, gnt: 1'b1, exp_req: 1'b0, exp_stall: 1'b1};
      vecs[2] = '{rst: 1'b0, flush: 1'b0, gnt: 1'b1, exp_req: 1'b1, exp_stall: 1'b0};
      vecs[3] = '{rst: 1'b0, flush: 1'b0, gnt: 1'b0, exp_req: 1'b1, exp_stall: 1'b1};
      vecs[4] = '{rst: 1'b0, flush: 1'b1, gnt: 1'b1, exp_req: 1'b0, exp_stall: 1'b0};
      vecs[5] = '{rst: 1'b0, flush: 1'b1, gnt: 1'b0, exp_req: 1'b0, exp_stall: 1'b0};

      @(posedge clk_i);
      @(posedge clk_i);
      @(negedge clk_i);

      // Request/stall decode from the empty state; every edge is a reset so the state stays empty.
      for (int i = 0; i < 6; i++) begin
         rst_i      = vecs[i].rst;
         flush_i    = vecs[i].flush;
         imem_gnt_i = vecs[i].gnt;
         #1;
         check($sformatf("vec%0d_req", i), 32'(imem_req_o), 32'(vecs[i].exp_req));
         check($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(vecs[i].exp_stall));
         rst_i   = 1'b1;
         flush_i = 1'b0;
         @(posedge clk_i);
         @(negedge clk_i);
      end

      do_reset();
      check("rst_valid", 32'(id_valid_o), 32'd0);
      check("rst_instr", id_instr_o, 32'd0);
      check("rst_pc", id_pc_o, 32'd0);
      check("rst_fault", 32'(id_fault_o), 32'd0);

      // Steady stream: one fetch per cycle, decode valid every cycle from the third.
      gnt_en = 1'b1; rsp_en = 1'b1; id_ready_i = 1'b1;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (s_stall) cnt_a++;
         if (i >= 2 && s_valid) cnt_b++;
      end
      check("steady_stalls", 32'(cnt_a), 32'd0);
      check("steady_valid_cycles", 32'(cnt_b), 32'd8);

      // Backpressure: FIFO fills, requests stop, PC held, head entry stable.
      id_ready_i = 1'b0;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (s_stall) cnt_a++;
         if (s_req) cnt_b++;
      end
      check("bp_stalls", 32'(cnt_a), 32'd5);
      check("bp_reqs", 32'(cnt_b), 32'd0);
      check("bp_valid", 32'(s_valid), 32'd1);
      check("bp_head_pc", s_pc, exp_q.size() > 0 ? exp_q[0].pc : 32'hDEAD_BEEF);
      check("bp_queued", 32'(exp_q.size()), 32'd2);
      id_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) step();
      drain("bp_drain");

      // Bus error at 0x8 becomes a faulting NOP; the next entry is clean.
      do_reset();
      err_addr = 32'h8;
      gnt_en = 1'b1; rsp_en = 1'b1; id_ready_i = 1'b1;
      n_fault = 0;
      for (int i = 0; i < 8; i++) step();
      drain("err_drain");
      check("err_fault_count", 32'(n_fault), 32'd1);

      // Flush from empty (no discard), then flush with 0x10/0x14 in flight.
      do_reset();
      gnt_en = 1'b1; rsp_en = 1'b1; id_ready_i = 1'b1;
      flush_target = 32'h10;
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("flush_empty_req", 32'(s_req), 32'd0);
      check("flush_empty_stall", 32'(s_stall), 32'd0);
      rsp_en = 1'b0;
      step();
      step();
      step();
      check("credit_block_req", 32'(s_req), 32'd0);
      check("inflight", 32'(mq.size()), 32'd2);
      flush_target = 32'h100;
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      rsp_en = 1'b1;
      step();
      check("flush_valid_low", 32'(s_valid), 32'd0);
      n_xfer = 0;
      for (int i = 0; i < 6; i++) step();
      drain("flush2_drain");
      check("flush2_delivered", 32'(n_xfer > 0), 32'd1);

      // Response and flush in the same cycle with one request outstanding.
      do_reset();
      gnt_en = 1'b1; rsp_en = 1'b0; id_ready_i = 1'b1;
      step();
      gnt_en = 1'b0;
      step();
      gnt_en = 1'b1; rsp_en = 1'b1;
      flush_target = 32'h200;
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      step();
      check("flush_rsp_valid_low", 32'(s_valid), 32'd0);
      for (int i = 0; i < 4; i++) step();
      drain("flush_rsp_drain");

      // Reset mid-stream with a response arriving during reset.
      do_reset();
      gnt_en = 1'b1; rsp_en = 1'b1; id_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) step();
      id_ready_i = 1'b0;
      step();
      rst_i = 1'b1;
      step();
      check("midrst_req", 32'(s_req), 32'd0);
      check("midrst_stall", 32'(s_stall), 32'd1);
      rst_i = 1'b0;
      #1;
      check("midrst_valid", 32'(id_valid_o), 32'd0);
      check("midrst_id_pc", id_pc_o, 32'd0);
      id_ready_i = 1'b1;
      step();
      check("midrst_first_req", 32'(s_req), 32'd1);
      check("midrst_first_addr", s_addr, 32'd0);
      for (int i = 0; i < 4; i++) step();
      drain("midrst_drain");

      // Random traffic with random flushes and a faulting address.
      do_reset();
      err_addr = 32'h40;
      for (int i = 0; i < 400; i++) begin
         gnt_en       = ($urandom_range(0, 3) != 0);
         rsp_en       = ($urandom_range(0, 3) != 0);
         id_ready_i   = ($urandom_range(0, 2) != 0);
         flush_i      = ($urandom_range(0, 24) == 0);
         flush_target = 32'($urandom_range(0, 63)) << 2;
         step();
         flush_i = 1'b0;
      end
      drain("rand_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
